mpmc11_rdata_capture: RTL and testbench

//  Consumes memory read-data beats for a cache-load burst, counts strips, packs them into

---
 rtl/mpmc11_pkg.sv | 23 ++
 rtl/mpmc11_line_packer.sv | 76 +++++++
 rtl/mpmc11_rdata_capture.sv | 134 +++++++++++++
 tb/tb_mpmc11_rdata_capture.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpmc11_pkg.sv
// Shared types for the mpmc11 read-data capture path: controller states, capture FSM states
// and the default strip geometry.
package mpmc11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        PRESET1    = 3'd1,
        PRESET2    = 3'd2,
        READ_DATA0 = 3'd3,
        READ_DATA1 = 3'd4,
        WRITE_DATA = 3'd5
    } mpmc11_state_t;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_COLLECT = 2'd2
    } mpmc11_cap_state_t;

    localparam int MPMC11_STRIP_WID   = 128;
    localparam int MPMC11_STRIP_BYTES = MPMC11_STRIP_WID / 8;

endpackage

// File: rtl/mpmc11_line_packer.sv
// Packs accepted strips into a cache line and registers one write per full line, last beat or flush.
// Latency 1 cycle from the completing accept to wr; no backpressure (cache always takes the write).
module mpmc11_line_packer
    import mpmc11_pkg::*;
#(
    parameter int STRIP_WID       = MPMC11_STRIP_WID,
    parameter int STRIPS_PER_LINE = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   accept,
    input  logic                                   last,
    input  logic                                   flush,
    input  logic                                   abort,
    input  logic [STRIP_WID-1:0]                   dat,
    input  logic [31:0]                            waddr,
    output logic                                   wr,
    output logic [31:0]                            wadr,
    output logic [STRIP_WID*STRIPS_PER_LINE-1:0]   wdat,
    output logic [STRIP_WID/8*STRIPS_PER_LINE-1:0] wsel,
    output logic                                   done
);

    localparam int SB         = STRIP_WID / 8;
    localparam int FILL_W     = (STRIPS_PER_LINE > 1) ? $clog2(STRIPS_PER_LINE) : 1;
    localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(STRIPS_PER_LINE - 1);
    localparam logic [31:0]   OFF_MASK  = 32'(SB * STRIPS_PER_LINE - 1);

    logic [STRIPS_PER_LINE-1:0][STRIP_WID-1:0] line_q, line_d;
    logic [STRIPS_PER_LINE-1:0][SB-1:0]        sel_q, sel_d;
    logic [FILL_W-1:0]                         fill_q;
    logic                                      line_full;
    logic                                      wr_now;

    always_comb begin
        line_d = line_q;
        sel_d  = sel_q;
        if (accept) begin
            line_d[fill_q] = dat;
            sel_d[fill_q]  = '1;
        end
        line_full = accept && ((fill_q == LAST_SLOT) || last);
        // A flush with nothing buffered must not produce an empty write.
        wr_now    = !abort && (line_full || (flush && (|sel_q)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
            sel_q  <= '0;
            fill_q <= '0;
            wr     <= 1'b0;
            wadr   <= '0;
            wdat   <= '0;
            wsel   <= '0;
            done   <= 1'b0;
        end else begin
            line_q <= line_d;
            wr     <= wr_now;
            done   <= !abort && accept && last;
            if (abort || wr_now) begin
                fill_q <= '0;
                sel_q  <= '0;
            end else if (accept) begin
                fill_q <= fill_q + 1'b1;
                sel_q  <= sel_d;
            end
            if (wr_now) begin
                wadr <= waddr & ~OFF_MASK;
                wdat <= line_d;
                wsel <= sel_d;
            end
        end
    end

endmodule

// File: rtl/mpmc11_rdata_capture.sv
// Captures a cache-load burst of read beats into cache-line writes; write latency 1 cycle after accept
// (2 with MPMC11_RDATA_OREG_EN); no backpressure, rd_valid outside collection is dropped.
module mpmc11_rdata_capture
    import mpmc11_pkg::*;
#(
    parameter int STRIP_WID       = MPMC11_STRIP_WID,
    parameter int STRIPS_PER_LINE = 2,
    parameter int TIMEOUT         = 255
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  mpmc11_state_t                          state,
    input  logic [5:0]                             num_strips,
    input  logic                                   rd_valid,
    input  logic [STRIP_WID-1:0]                   rd_data,
    input  logic [31:0]                            waddr,
    output logic [5:0]                             strip_cnt,
    output logic                                   beat_valid,
    output logic                                   cwr,
    output logic [31:0]                            cwadr,
    output logic [STRIP_WID*STRIPS_PER_LINE-1:0]   cwdat,
    output logic [STRIP_WID/8*STRIPS_PER_LINE-1:0] cwsel,
    output logic                                   done,
    output logic                                   err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    mpmc11_cap_state_t cap_q, cap_d;
    logic [5:0]        cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              err_d;
    logic              preset, accept, is_last, timeout;

    logic                                   pk_wr, pk_done;
    logic [31:0]                            pk_adr;
    logic [STRIP_WID*STRIPS_PER_LINE-1:0]   pk_dat;
    logic [STRIP_WID/8*STRIPS_PER_LINE-1:0] pk_sel;

    always_comb begin
        preset  = (state == PRESET2);
        accept  = rd_valid && (cap_q == CAP_COLLECT);
        is_last = (strip_cnt == num_strips);
        timeout = (cap_q == CAP_COLLECT) && !accept && (timer_q == TW'(TIMEOUT - 1));
        cap_d   = cap_q;
        cnt_d   = strip_cnt;
        timer_d = '0;
        err_d   = err;
        case (cap_q)
            CAP_ARMED: begin
                if (state == READ_DATA0) cap_d = CAP_COLLECT;
            end
            CAP_COLLECT: begin
                // An accept in the terminal timer cycle wins and reloads the timer.
                if (accept) begin
                    if (is_last) cap_d = CAP_IDLE;
                    else         cnt_d = strip_cnt + 6'd1;
                end else if (timeout) begin
                    cap_d = CAP_IDLE;
                    err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (preset) begin
            cap_d   = CAP_ARMED;
            cnt_d   = '0;
            timer_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_q     <= CAP_IDLE;
            strip_cnt <= '0;
            timer_q   <= '0;
            err       <= 1'b0;
        end else begin
            cap_q     <= cap_d;
            strip_cnt <= cnt_d;
            timer_q   <= timer_d;
            err       <= err_d;
        end
    end

    assign beat_valid = accept;

    mpmc11_line_packer #(
        .STRIP_WID       (STRIP_WID),
        .STRIPS_PER_LINE (STRIPS_PER_LINE)
    ) u_packer (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .last   (accept && is_last),
        .flush  (timeout),
        .abort  (preset),
        .dat    (rd_data),
        .waddr  (waddr),
        .wr     (pk_wr),
        .wadr   (pk_adr),
        .wdat   (pk_dat),
        .wsel   (pk_sel),
        .done   (pk_done)
    );

`ifdef MPMC11_RDATA_OREG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cwr   <= 1'b0;
            cwadr <= '0;
            cwdat <= '0;
            cwsel <= '0;
            done  <= 1'b0;
        end else begin
            cwr   <= pk_wr;
            cwadr <= pk_adr;
            cwdat <= pk_dat;
            cwsel <= pk_sel;
            done  <= pk_done;
        end
    end
`else
    assign cwr   = pk_wr;
    assign cwadr = pk_adr;
    assign cwdat = pk_dat;
    assign cwsel = pk_sel;
    assign done  = pk_done;
`endif

endmodule

// File: tb/tb_mpmc11_rdata_capture.sv
// Directed bench for mpmc11_rdata_capture: bursts, partial lines, timeout, dropped beats, async reset.
module tb_mpmc11_rdata_capture;
    import mpmc11_pkg::*;

    localparam int SW = 128;
    localparam int TO = 255;
`ifdef MPMC11_RDATA_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [255:0] FULL_M = {256{1'b1}};
    localparam logic [255:0] LOW_M  = {{128{1'b0}}, {128{1'b1}}};

    logic          clk;
    logic          rst;
    mpmc11_state_t state;
    logic [5:0]    num_strips;
    logic          rd_valid;
    logic [SW-1:0] rd_data;
    logic [31:0]   waddr;
    logic [5:0]    strip_cnt;
    logic          beat_valid;
    logic          cwr;
    logic [31:0]   cwadr;
    logic [255:0]  cwdat;
    logic [31:0]   cwsel;
    logic          done;
    logic          err;

    mpmc11_rdata_capture #(
        .STRIP_WID       (SW),
        .STRIPS_PER_LINE (2),
        .TIMEOUT         (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .num_strips (num_strips),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .waddr      (waddr),
        .strip_cnt  (strip_cnt),
        .beat_valid (beat_valid),
        .cwr        (cwr),
        .cwadr      (cwadr),
        .cwdat      (cwdat),
        .cwsel      (cwsel),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        int           cyc;
        logic [31:0]  adr;
        logic [255:0] dat;
        logic [31:0]  sel;
        logic         dn;
    } wr_t;

    wr_t wq[$];
    int  cyc      = 0;
    int  done_cnt = 0;
    int  n_chk    = 0;
    int  n_pass   = 0;
    int  last_acc = 0;
    int  acc[4];
    int  dn0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cwr) wq.push_back('{cyc, cwadr, cwdat, cwsel, done});
        if (done) done_cnt++;
    end

    function automatic logic [127:0] dv(input int i);
        return {32'hA500_0000 + 32'(i), 32'h5A00_0000 + 32'(i),
                32'hF0F0_0000 + 32'(i), 32'h0F0F_0000 + 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [127:0] d, input logic [31:0] a);
        rd_valid = 1'b1;
        rd_data  = d;
        waddr    = a;
        #1;
        chk("beat_valid", beat_valid, 1);
        tick();
        last_acc = cyc;
        rd_valid = 1'b0;
    endtask

    task automatic start_burst(input logic [5:0] n);
        num_strips = n;
        state      = PRESET2;
        tick();
        state      = READ_DATA0;
        tick();
        state      = ST_IDLE;
    endtask

    task automatic check_wr(input string tag, input int exp_cyc, input logic [31:0] adr,
                            input logic [255:0] dat, input logic [255:0] dmask,
                            input logic [31:0] sel, input logic dn);
        wr_t e;
        chk({tag, "_present"}, wq.size() > 0, 1);
        if (wq.size() == 0) return;
        e = wq.pop_front();
        chk({tag, "_cyc"}, e.cyc, exp_cyc);
        chk({tag, "_adr"}, e.adr, adr);
        chk({tag, "_dat"}, e.dat & dmask, dat & dmask);
        chk({tag, "_sel"}, e.sel, sel);
        chk({tag, "_done"}, e.dn, dn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        state      = ST_IDLE;
        num_strips = '0;
        rd_valid   = 1'b0;
        rd_data    = '0;
        waddr      = '0;
        #23;
        chk("rst_strip_cnt", strip_cnt, 0);
        chk("rst_cwr", cwr, 0);
        chk("rst_cwadr", cwadr, 0);
        chk("rst_cwdat", cwdat, 0);
        chk("rst_cwsel", cwsel, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Four back-to-back beats, two full lines; line offset bits of waddr are masked off.
        wq.delete();
        dn0 = done_cnt;
        start_burst(6'd3);
        beat(dv(0), 32'h100); acc[0] = last_acc;
        beat(dv(1), 32'h110); acc[1] = last_acc;
        beat(dv(2), 32'h120); acc[2] = last_acc;
        beat(dv(3), 32'h130); acc[3] = last_acc;
        chk("t1_strip_cnt", strip_cnt, 3);
        repeat (3) tick();
        chk("t1_nwr", wq.size(), 2);
        check_wr("t1_w0", acc[1] + LAT - 1, 32'h100, {dv(1), dv(0)}, FULL_M, 32'hFFFF_FFFF, 1'b0);
        check_wr("t1_w1", acc[3] + LAT - 1, 32'h120, {dv(3), dv(2)}, FULL_M, 32'hFFFF_FFFF, 1'b1);
        chk("t1_done_cnt", done_cnt - dn0, 1);
        chk("t1_err", err, 0);

        // Beats after done are dropped.
        rd_valid = 1'b1;
        rd_data  = dv(9);
        #1;
        chk("t4_after_bv", beat_valid, 0);
        repeat (3) tick();
        rd_valid = 1'b0;
        repeat (2) tick();
        chk("t4_after_cnt", strip_cnt, 3);
        chk("t4_after_nwr", wq.size(), 0);

        // Beats while armed (before READ_DATA0) are dropped.
        num_strips = 6'd1;
        state      = PRESET2;
        tick();
        state      = ST_IDLE;
        rd_valid   = 1'b1;
        rd_data    = dv(7);
        #1;
        chk("t4_armed_bv", beat_valid, 0);
        repeat (2) tick();
        rd_valid = 1'b0;
        chk("t4_armed_cnt", strip_cnt, 0);
        chk("t4_armed_nwr", wq.size(), 0);

        // Three-beat burst ends with a half-filled line.
        wq.delete();
        start_burst(6'd2);
        beat(dv(4), 32'h200); acc[1] = last_acc;
        beat(dv(5), 32'h210); acc[1] = last_acc;
        beat(dv(6), 32'h220); acc[2] = last_acc;
        chk("t2_strip_cnt", strip_cnt, 2);
        repeat (3) tick();
        chk("t2_nwr", wq.size(), 2);
        check_wr("t2_w0", acc[1] + LAT - 1, 32'h200, {dv(5), dv(4)}, FULL_M, 32'hFFFF_FFFF, 1'b0);
        check_wr("t2_w1", acc[2] + LAT - 1, 32'h220, {128'b0, dv(6)}, LOW_M, 32'h0000_FFFF, 1'b1);

        // Two beats of a four-beat burst, then silence until timeout.
        wq.delete();
        dn0 = done_cnt;
        start_burst(6'd3);
        beat(dv(10), 32'h300);
        beat(dv(11), 32'h310); acc[1] = last_acc;
        repeat (TO - 1) tick();
        chk("t3_err_early", err, 0);
        tick();
        chk("t3_err_set", err, 1);
        rd_valid = 1'b1;
        rd_data  = dv(14);
        #1;
        chk("t3_idle_bv", beat_valid, 0);
        rd_valid = 1'b0;
        repeat (3) tick();
        chk("t3_nwr", wq.size(), 1);
        check_wr("t3_w0", acc[1] + LAT - 1, 32'h300, {dv(11), dv(10)}, FULL_M, 32'hFFFF_FFFF, 1'b0);
        chk("t3_no_done", done_cnt - dn0, 0);
        chk("t3_strip_cnt", strip_cnt, 2);
        state = PRESET2;
        tick();
        state = ST_IDLE;
        chk("t3_err_clr", err, 0);

        // Asynchronous reset in the middle of a burst.
        wq.delete();
        start_burst(6'd3);
        beat(dv(12), 32'h400);
        rd_valid = 1'b1;
        rd_data  = dv(13);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_strip_cnt", strip_cnt, 0);
        chk("t5_bv", beat_valid, 0);
        chk("t5_cwr", cwr, 0);
        chk("t5_cwadr", cwadr, 0);
        chk("t5_cwdat", cwdat, 0);
        chk("t5_cwsel", cwsel, 0);
        chk("t5_done", done, 0);
        rd_valid = 1'b0;
        #3;
        rst = 1'b1;
        repeat (4) tick();
        chk("t5_nwr", wq.size(), 0);
        chk("t5_cnt_after", strip_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
